// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative radix-2 multiply/divide unit owning HI/LO (optional MULDIV_EARLY_OUT_EN)
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] gr1,
  input  logic [WIDTH-1:0] gr2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   mag_b;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;        // {partial product high | remainder, multiplier | quotient}
  logic [CNT_W-1:0]   cnt;
  logic               res_neg;
  logic               rem_neg;
  logic               ovf_q;
  logic               dz_q;

  logic               a_neg, b_neg, dz_in;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  // Operand magnitudes, one iteration step of each datapath, and final sign correction
  always_comb begin
    a_neg    = ~op[0] & gr1[WIDTH-1];
    b_neg    = ~op[0] & gr2[WIDTH-1];
    mag_a_in = a_neg ? -gr1 : gr1;
    mag_b_in = b_neg ? -gr2 : gr2;
    dz_in    = op[1] && (gr2 == '0);

    mul_add  = acc[0] ? mag_b : {WIDTH{1'b0}};
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, mag_b};
    div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod_fix = res_neg ? -acc : acc;
    quo_fix  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_hi   = op_q[1] ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = op_q[1] ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // Control FSM, iteration datapath, HI/LO registers and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= 2'b00;
      mag_b       <= '0;
      acc         <= '0;
      cnt         <= '0;
      res_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      zero        <= 1'b0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      // mthi/mtlo land first so that a completing operation in the same edge wins
      if (!busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            mag_b   <= mag_b_in;
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            ovf_q   <= (op == 2'b10) && (gr1 == {1'b1, {(WIDTH-1){1'b0}}}) && (gr2 == {WIDTH{1'b1}});
            dz_q    <= dz_in;
            cnt     <= '0;
            if (dz_in) begin
              state <= S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
            end else if (!op[1] && (mag_a_in == '0 || mag_b_in == '0)) begin
              acc   <= '0;
              state <= S_FIX;
            end else if (op[1] && (mag_a_in < mag_b_in)) begin
              acc   <= {mag_a_in, {WIDTH{1'b0}}};
              state <= S_FIX;
`endif
            end else begin
              acc   <= {{WIDTH{1'b0}}, mag_a_in};
              busy  <= 1'b1;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= S_FIX;
        end
        S_FIX: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
          if (dz_q) begin
            div_by_zero <= 1'b1;
            zero        <= 1'b0;
            negative    <= 1'b0;
            overflow    <= 1'b0;
          end else begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            div_by_zero <= 1'b0;
            overflow    <= ovf_q;
            zero        <= op_q[1] ? (fix_lo == '0) : ({fix_hi, fix_lo} == '0);
            negative    <= op_q[0] ? 1'b0 : (op_q[1] ? fix_lo[WIDTH-1] : fix_hi[WIDTH-1]);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit against an arithmetic model
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] gr1 = '0, gr2 = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, zero, negative, overflow, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .gr1(gr1), .gr2(gr2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .zero(zero), .negative(negative), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from signed/unsigned arithmetic
  function automatic void model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l,
                                    output logic z, output logic n, output logic ov);
    longint sa, sb;
    int     qa, qb;
    logic [63:0] p;
    ov = 1'b0;
    h = '0; l = '0; z = 1'b0; n = 1'b0;
    case (o)
      2'b00: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p = 64'(sa * sb);
        h = p[63:32]; l = p[31:0]; z = (p == 64'd0); n = h[31];
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32]; l = p[31:0]; z = (p == 64'd0); n = 1'b0;
      end
      2'b10: begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          l = 32'h80000000; h = 32'd0; ov = 1'b1;
        end else begin
          qa = $signed(a); qb = $signed(b);
          l = 32'(qa / qb); h = 32'(qa % qb);
        end
        z = (l == 32'd0); n = l[31];
      end
      default: begin
        l = a / b; h = a % b; z = (l == 32'd0); n = 1'b0;
      end
    endcase
  endfunction

  // Cycle-level expectation: pending result released after a countdown
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic m_z = 0, m_n = 0, m_o = 0, m_dz = 0, m_busy = 0, m_done = 0;
  logic p_z = 0, p_n = 0, p_o = 0, p_dz = 0;
  int   cd = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_z = 0; m_n = 0; m_o = 0; m_dz = 0;
      m_busy = 0; m_done = 0; cd = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          m_done = 1; m_busy = 0;
          if (p_dz) begin
            m_dz = 1; m_z = 0; m_n = 0; m_o = 0;
          end else begin
            m_hi = p_hi; m_lo = p_lo; m_z = p_z; m_n = p_n; m_o = p_o; m_dz = 0;
          end
        end
      end else if (start) begin
        if (op[1] && gr2 == 32'd0) begin
          p_dz = 1; cd = 1;
        end else begin
          model_res(op, gr1, gr2, p_hi, p_lo, p_z, p_n, p_o);
          p_dz = 0; cd = 33; m_busy = 1;
        end
      end
    end
  end

  // Compare every output against the model each cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_busy", busy, m_busy);
      chk("cmp_done", done, m_done);
      chk("cmp_hi", hi, m_hi);
      chk("cmp_lo", lo, m_lo);
      chk("cmp_zero", zero, m_z);
      chk("cmp_negative", negative, m_n);
      chk("cmp_overflow", overflow, m_o);
      chk("cmp_div_by_zero", div_by_zero, m_dz);
      chk("cmp_busy_done_excl", busy & done, 0);
    end
  end

  // Issue one operation from a negedge and wait for done; returns on the done negedge
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic hwe, input logic lwe, input logic [31:0] wd, input int poke,
                       input int exp_lat, input logic [31:0] eh, input logic [31:0] el);
    int n;
    start = 1'b1; op = o; gr1 = a; gr2 = b;
    hi_we = hwe; lo_we = lwe; wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == poke) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
        op = 2'b01; gr1 = 32'd1; gr2 = 32'd1;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'($urandom); gr1 = $urandom; gr2 = $urandom;
      end
    end while (!done && n < 40);
    chk({name, "_done_seen"}, done, 1'b1);
    chk({name, "_latency"}, n - 1, exp_lat);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
  endtask

  task automatic write_regs(input logic hwe, input logic lwe, input logic [31:0] wd);
    hi_we = hwe; lo_we = lwe; wdata = wd;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("mult_m1x2", 2'b00, 32'hFFFFFFFF, 32'h2, 0, 0, 0, 0, 33, 32'hFFFFFFFF, 32'hFFFFFFFE);
    chk("mult_m1x2_negative", negative, 1);
    do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 33, 32'hFFFFFFFE, 32'h00000001);
    chk("multu_max_negative", negative, 0);
    chk("multu_max_zero", zero, 0);
    do_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'h2, 0, 0, 0, 0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("divu_7d2", 2'b11, 32'd7, 32'd2, 0, 0, 0, 0, 33, 32'd1, 32'd3);
    do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 33, 32'd0, 32'h80000000);
    chk("div_ovf_flag", overflow, 1);
    do_op("divu_9d3", 2'b11, 32'd9, 32'd3, 0, 0, 0, 0, 33, 32'd0, 32'd3);
    chk("divu_9d3_ovf_clear", overflow, 0);

    write_regs(0, 1, 32'h1234);
    chk("mtlo_lo", lo, 32'h1234);
    do_op("div_by0", 2'b10, 32'd5, 32'd0, 0, 0, 0, 0, 1, 32'd0, 32'h1234);
    chk("div_by0_flag", div_by_zero, 1);
    do_op("divu_by0_mthi", 2'b11, 32'd8, 32'd0, 1, 0, 32'h77, 0, 1, 32'h77, 32'h1234);

    write_regs(1, 1, 32'hA5A5);
    chk("mthi_mtlo_hi", hi, 32'hA5A5);
    chk("mthi_mtlo_lo", lo, 32'hA5A5);
    do_op("multu_wr_same", 2'b01, 32'd3, 32'd5, 1, 1, 32'h5555, 0, 33, 32'd0, 32'd15);
    do_op("divu_busy_poke", 2'b11, 32'd100, 32'd7, 0, 0, 0, 5, 33, 32'd2, 32'd14);
    do_op("div_7dm2", 2'b10, 32'd7, 32'hFFFFFFFE, 0, 0, 0, 0, 33, 32'd1, 32'hFFFFFFFD);
    do_op("div_m7dm2", 2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 0, 0, 0, 0, 33, 32'hFFFFFFFF, 32'd3);
    do_op("mult_m3xm4", 2'b00, 32'hFFFFFFFD, 32'hFFFFFFFC, 0, 0, 0, 0, 33, 32'd0, 32'd12);
    do_op("mult_0x5", 2'b00, 32'd0, 32'd5, 0, 0, 0, 0, 33, 32'd0, 32'd0);
    chk("mult_0x5_zero", zero, 1);
    do_op("div_0d5", 2'b10, 32'd0, 32'd5, 0, 0, 0, 0, 33, 32'd0, 32'd0);
    chk("div_0d5_zero", zero, 1);

    start = 1'b1; op = 2'b00; gr1 = 32'h12345678; gr2 = 32'h9ABCDEF0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (i == 10) rst_n = 1'b0;
    end
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("mult_3x4", 2'b00, 32'd3, 32'd4, 0, 0, 0, 0, 33, 32'd0, 32'd12);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
